// File: rtl/freq_monitor_pkg.sv
// Shared types and helpers for the refclk-domain frequency lock monitor.
package freq_monitor_pkg;

  typedef enum logic [1:0] {
    DISCARD,
    ACQUIRE,
    LOCKED,
    HOLD
  } fm_state_t;

  // Width of an estimator count that can reach factor*period.
  function automatic int fm_width(input int factor, input int period);
    return $clog2(factor * period);
  endfunction

endpackage

// File: rtl/freq_sample_timer.sv
// Free-running modulo-PERIOD counter that emits a tick in its last count.
module freq_sample_timer #(
  parameter int PERIOD = 1000
) (
  input  logic refclk,
  input  logic reset_n,
  output logic tick
);

  localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [TW-1:0] LAST = TW'(PERIOD - 1);

  logic [TW-1:0] tcnt;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge refclk) begin
    if (!reset_n) begin
      tcnt <= '0;
    end else if (tcnt == LAST) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  assign tick = (tcnt == LAST);

endmodule

// File: rtl/freq_lock_monitor.sv
// Samples the estimator count once per period, classifies it against runtime
// limits, runs a debounced lock FSM and tracks the extreme samples seen.
module freq_lock_monitor
  import freq_monitor_pkg::*;
#(
  parameter int  PERIOD     = 1000,
  parameter int  FACTOR     = 2,
  parameter int  LOCK_CNT   = 4,
  parameter int  UNLOCK_CNT = 2,
  localparam int FW         = fm_width(FACTOR, PERIOD)
) (
  input  logic          refclk,
  input  logic          reset_n,
  input  logic [FW-1:0] frequency,
  input  logic [FW-1:0] freq_min,
  input  logic [FW-1:0] freq_max,
  input  logic          clear,
  output logic          sample_stb,
  output logic [FW-1:0] freq_last,
  output logic          too_low,
  output logic          too_high,
  output logic          locked,
  output logic          lock_lost,
  output logic          lock_lost_sticky,
  output logic [FW-1:0] freq_lo_seen,
  output logic [FW-1:0] freq_hi_seen,
  output logic          seen_valid
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);

  fm_state_t     state;
  logic [GW-1:0] good_cnt;
  logic [BW-1:0] bad_cnt;
  logic          tick;
  logic          accept;
  logic          is_low;
  logic          is_high;
  logic          in_range;
  logic          do_unlock;

  freq_sample_timer #(
    .PERIOD (PERIOD)
  ) u_timer (
    .refclk  (refclk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  // Inverted limits make both flags unreachable together for no f, so nothing is in range.
  assign is_low   = (frequency < freq_min);
  assign is_high  = (frequency > freq_max);
  assign in_range = !is_low && !is_high;
  assign accept   = tick && (state != DISCARD);

  // NOTE: default assigned first so no path through the block infers a latch.
  always_comb begin
    do_unlock = 1'b0;
    if (accept && !in_range) begin
      if (state == LOCKED && UNLOCK_CNT == 1) do_unlock = 1'b1;
      if (state == HOLD && int'(bad_cnt) + 1 >= UNLOCK_CNT) do_unlock = 1'b1;
    end
  end

  always_ff @(posedge refclk) begin
    if (!reset_n) begin
      state            <= DISCARD;
      good_cnt         <= '0;
      bad_cnt          <= '0;
      sample_stb       <= 1'b0;
      freq_last        <= '0;
      too_low          <= 1'b0;
      too_high         <= 1'b0;
      locked           <= 1'b0;
      lock_lost        <= 1'b0;
      lock_lost_sticky <= 1'b0;
      freq_lo_seen     <= '0;
      freq_hi_seen     <= '0;
      seen_valid       <= 1'b0;
    end else begin
      sample_stb <= 1'b0;
      lock_lost  <= 1'b0;

      if (clear) begin
        lock_lost_sticky <= 1'b0;
        seen_valid       <= 1'b0;
        freq_lo_seen     <= '0;
        freq_hi_seen     <= '0;
      end

      if (tick && state == DISCARD) begin
        state <= ACQUIRE;
      end

      if (accept) begin
        sample_stb <= 1'b1;
        freq_last  <= frequency;
        too_low    <= is_low;
        too_high   <= is_high;

        // A same-cycle clear restarts the trackers from this sample.
        if (!seen_valid || clear) begin
          freq_lo_seen <= frequency;
          freq_hi_seen <= frequency;
          seen_valid   <= 1'b1;
        end else begin
          if (frequency < freq_lo_seen) freq_lo_seen <= frequency;
          if (frequency > freq_hi_seen) freq_hi_seen <= frequency;
        end

        case (state)
          ACQUIRE: begin
            if (!in_range) begin
              good_cnt <= '0;
            end else if (int'(good_cnt) + 1 >= LOCK_CNT) begin
              state    <= LOCKED;
              locked   <= 1'b1;
              good_cnt <= '0;
            end else begin
              good_cnt <= good_cnt + 1'b1;
            end
          end
          LOCKED: begin
            if (!in_range && UNLOCK_CNT > 1) begin
              state   <= HOLD;
              bad_cnt <= BW'(1);
            end
          end
          HOLD: begin
            if (in_range) begin
              state   <= LOCKED;
              bad_cnt <= '0;
            end else if (!do_unlock) begin
              bad_cnt <= bad_cnt + 1'b1;
            end
          end
          default: state <= DISCARD;
        endcase

        // Placed after the clear handling so a simultaneous unlock keeps sticky set.
        if (do_unlock) begin
          state            <= ACQUIRE;
          locked           <= 1'b0;
          lock_lost        <= 1'b1;
          lock_lost_sticky <= 1'b1;
          good_cnt         <= '0;
          bad_cnt          <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_freq_lock_monitor.sv
// Directed scenario bench for freq_lock_monitor with PERIOD=10, LOCK_CNT=3, UNLOCK_CNT=2.
module tb_freq_lock_monitor;

  localparam int PERIOD     = 10;
  // FACTOR widened so the count width (8 bits) holds the ~100-valued test counts.
  localparam int FACTOR     = 16;
  localparam int LOCK_CNT   = 3;
  localparam int UNLOCK_CNT = 2;
  localparam int FW         = $clog2(FACTOR * PERIOD);

  logic          refclk = 1'b0;
  logic          reset_n = 1'b0;
  logic [FW-1:0] frequency = '0;
  logic [FW-1:0] freq_min = '0;
  logic [FW-1:0] freq_max = '0;
  logic          clear = 1'b0;
  logic          sample_stb;
  logic [FW-1:0] freq_last;
  logic          too_low;
  logic          too_high;
  logic          locked;
  logic          lock_lost;
  logic          lock_lost_sticky;
  logic [FW-1:0] freq_lo_seen;
  logic [FW-1:0] freq_hi_seen;
  logic          seen_valid;

  int tests = 0;
  int fails = 0;
  int lost_pulses = 0;

  freq_lock_monitor #(
    .PERIOD     (PERIOD),
    .FACTOR     (FACTOR),
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_CNT (UNLOCK_CNT)
  ) dut (
    .refclk           (refclk),
    .reset_n          (reset_n),
    .frequency        (frequency),
    .freq_min         (freq_min),
    .freq_max         (freq_max),
    .clear            (clear),
    .sample_stb       (sample_stb),
    .freq_last        (freq_last),
    .too_low          (too_low),
    .too_high         (too_high),
    .locked           (locked),
    .lock_lost        (lock_lost),
    .lock_lost_sticky (lock_lost_sticky),
    .freq_lo_seen     (freq_lo_seen),
    .freq_hi_seen     (freq_hi_seen),
    .seen_valid       (seen_valid)
  );

  always #5 refclk = ~refclk;

  always @(negedge refclk) if (lock_lost === 1'b1) lost_pulses++;

  task automatic tick_cycle();
    @(posedge refclk);
    @(negedge refclk);
  endtask

  // Advance to the negedge after the next sample_stb; a missing strobe counts as a failure.
  task automatic wait_sample(input string name);
    bit got = 0;
    for (int i = 0; i < 2 * PERIOD + 2 && !got; i++) begin
      tick_cycle();
      if (sample_stb === 1'b1) got = 1;
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL %s: no sample_stb within %0d cycles", name, 2 * PERIOD + 2);
    end
  endtask

  // Counts cycles from reset release and records the first strobe and the lock rise.
  task automatic measure_lock(output int first_stb, output int lock_at, output int stb_cnt);
    first_stb = 0;
    lock_at   = 0;
    stb_cnt   = 0;
    for (int n = 1; n <= 45; n++) begin
      tick_cycle();
      if (sample_stb === 1'b1) begin
        stb_cnt++;
        if (first_stb == 0) first_stb = n;
      end
      if (locked === 1'b1 && lock_at == 0) lock_at = n;
    end
  endtask

  task automatic test_reset();
    frequency = 8'd100;
    freq_min  = 8'd95;
    freq_max  = 8'd105;
    reset_n   = 1'b0;
    repeat (3) @(negedge refclk);
    tests++;
    if ({sample_stb, too_low, too_high, locked, lock_lost, lock_lost_sticky, seen_valid} !== 7'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b want 0000000",
               {sample_stb, too_low, too_high, locked, lock_lost, lock_lost_sticky, seen_valid});
    end
    tests++;
    if ({freq_last, freq_lo_seen, freq_hi_seen} !== '0) begin
      fails++;
      $display("FAIL reset_values: last=%0d lo=%0d hi=%0d want 0/0/0", freq_last, freq_lo_seen, freq_hi_seen);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_lock_timing(input string tag);
    int first_stb, lock_at, stb_cnt;
    measure_lock(first_stb, lock_at, stb_cnt);
    tests++;
    if (first_stb != 20) begin
      fails++;
      $display("FAIL %s_first_stb: cycle %0d want 20", tag, first_stb);
    end
    tests++;
    if (lock_at != 40) begin
      fails++;
      $display("FAIL %s_lock_rise: cycle %0d want 40", tag, lock_at);
    end
    tests++;
    if (stb_cnt != 3) begin
      fails++;
      $display("FAIL %s_stb_count: %0d want 3", tag, stb_cnt);
    end
    tests++;
    if ({too_low, too_high} !== 2'b00 || freq_last !== 8'd100) begin
      fails++;
      $display("FAIL %s_class: low=%b high=%b last=%0d want 0 0 100", tag, too_low, too_high, freq_last);
    end
  endtask

  task automatic test_too_high_glitch();
    int lost0 = lost_pulses;
    frequency = 8'd110;
    wait_sample("glitch_s1");
    tests++;
    if (too_high !== 1'b1 || too_low !== 1'b0 || locked !== 1'b1 || freq_last !== 8'd110) begin
      fails++;
      $display("FAIL glitch_high: high=%b low=%b locked=%b last=%0d want 1 0 1 110",
               too_high, too_low, locked, freq_last);
    end
    tick_cycle();
    tests++;
    if (sample_stb !== 1'b0) begin
      fails++;
      $display("FAIL stb_width: sample_stb=%b one cycle later, want 0", sample_stb);
    end
    frequency = 8'd100;
    wait_sample("glitch_s2");
    tests++;
    if (too_high !== 1'b0 || locked !== 1'b1 || lost_pulses != lost0) begin
      fails++;
      $display("FAIL glitch_recover: high=%b locked=%b lost_pulses=%0d want 0 1 0",
               too_high, locked, lost_pulses - lost0);
    end
  endtask

  task automatic test_unlock_relock();
    int lost0 = lost_pulses;
    frequency = 8'd90;
    wait_sample("unlock_s1");
    tests++;
    if (too_low !== 1'b1 || locked !== 1'b1) begin
      fails++;
      $display("FAIL hold_first_low: low=%b locked=%b want 1 1", too_low, locked);
    end
    wait_sample("unlock_s2");
    tests++;
    if (locked !== 1'b0 || lock_lost !== 1'b1 || lock_lost_sticky !== 1'b1) begin
      fails++;
      $display("FAIL unlock: locked=%b lost=%b sticky=%b want 0 1 1", locked, lock_lost, lock_lost_sticky);
    end
    frequency = 8'd100;
    tick_cycle();
    tests++;
    if (lock_lost !== 1'b0 || lost_pulses - lost0 != 1) begin
      fails++;
      $display("FAIL lost_pulse: lost=%b pulses=%0d want 0 1", lock_lost, lost_pulses - lost0);
    end
    wait_sample("relock_s1");
    wait_sample("relock_s2");
    tests++;
    if (locked !== 1'b0) begin
      fails++;
      $display("FAIL early_relock: locked=%b after 2 good samples, want 0", locked);
    end
    wait_sample("relock_s3");
    tests++;
    if (locked !== 1'b1 || lock_lost_sticky !== 1'b1) begin
      fails++;
      $display("FAIL relock: locked=%b sticky=%b want 1 1", locked, lock_lost_sticky);
    end
  endtask

  task automatic test_trackers_clear();
    clear = 1'b1;
    tick_cycle();
    clear = 1'b0;
    tests++;
    if (seen_valid !== 1'b0 || freq_lo_seen !== 8'd0 || freq_hi_seen !== 8'd0 || lock_lost_sticky !== 1'b0) begin
      fails++;
      $display("FAIL clear_idle: valid=%b lo=%0d hi=%0d sticky=%b want 0 0 0 0",
               seen_valid, freq_lo_seen, freq_hi_seen, lock_lost_sticky);
    end
    frequency = 8'd100;
    wait_sample("trk_s1");
    tests++;
    if (seen_valid !== 1'b1 || freq_lo_seen !== 8'd100 || freq_hi_seen !== 8'd100) begin
      fails++;
      $display("FAIL trk_first: valid=%b lo=%0d hi=%0d want 1 100 100", seen_valid, freq_lo_seen, freq_hi_seen);
    end
    frequency = 8'd97;
    wait_sample("trk_s2");
    frequency = 8'd104;
    wait_sample("trk_s3");
    tests++;
    if (freq_lo_seen !== 8'd97 || freq_hi_seen !== 8'd104) begin
      fails++;
      $display("FAIL trk_minmax: lo=%0d hi=%0d want 97 104", freq_lo_seen, freq_hi_seen);
    end
    frequency = 8'd99;
    repeat (PERIOD - 1) tick_cycle();
    clear = 1'b1;
    tick_cycle();
    clear = 1'b0;
    tests++;
    if (sample_stb !== 1'b1 || seen_valid !== 1'b1 || freq_lo_seen !== 8'd99 ||
        freq_hi_seen !== 8'd99 || lock_lost_sticky !== 1'b0) begin
      fails++;
      $display("FAIL clear_on_tick: stb=%b valid=%b lo=%0d hi=%0d sticky=%b want 1 1 99 99 0",
               sample_stb, seen_valid, freq_lo_seen, freq_hi_seen, lock_lost_sticky);
    end
    tests++;
    if (locked !== 1'b1) begin
      fails++;
      $display("FAIL clear_keeps_lock: locked=%b want 1", locked);
    end
  endtask

  task automatic test_reset_midrun();
    frequency = 8'd100;
    reset_n = 1'b0;
    tick_cycle();
    reset_n = 1'b1;
    tests++;
    if ({sample_stb, too_low, too_high, locked, lock_lost, lock_lost_sticky, seen_valid} !== 7'b0 ||
        {freq_last, freq_lo_seen, freq_hi_seen} !== '0) begin
      fails++;
      $display("FAIL midrun_reset: flags=%b last=%0d lo=%0d hi=%0d want all 0",
               {sample_stb, too_low, too_high, locked, lock_lost, lock_lost_sticky, seen_valid},
               freq_last, freq_lo_seen, freq_hi_seen);
    end
    test_lock_timing("rerun");
  endtask

  task automatic test_inverted_limits();
    bit ever_locked = 0;
    logic [FW-1:0] f_tab   [3] = '{8'd100, 8'd105, 8'd115};
    logic [1:0]    exp_tab [3] = '{2'b10, 2'b11, 2'b01};
    freq_min  = 8'd110;
    freq_max  = 8'd100;
    frequency = f_tab[0];
    reset_n   = 1'b0;
    tick_cycle();
    reset_n   = 1'b1;
    for (int k = 0; k < 5; k++) begin
      int idx = (k < 3) ? k : 2;
      frequency = f_tab[idx];
      wait_sample("inv_sample");
      if (locked === 1'b1) ever_locked = 1;
      tests++;
      if ({too_low, too_high} !== exp_tab[idx]) begin
        fails++;
        $display("FAIL inv_class f=%0d: low,high=%b want %b", f_tab[idx], {too_low, too_high}, exp_tab[idx]);
      end
    end
    tests++;
    if (ever_locked || locked !== 1'b0) begin
      fails++;
      $display("FAIL inv_never_locked: ever=%b locked=%b want 0 0", ever_locked, locked);
    end
  endtask

  initial begin
    @(negedge refclk);
    test_reset();
    test_lock_timing("reset");
    test_too_high_glitch();
    test_unlock_relock();
    test_trackers_clear();
    test_reset_midrun();
    test_inverted_limits();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
